// File: rtl/vga_capture_if.sv
// Video-in and frame-out signal bundle for vga_capture.
// The slave side is the capture block; the master side drives video and consumes frames.
interface vga_capture_if;
    logic        hsync;
    logic        vsync;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;
    logic [63:0] frame_data;
    logic        frame_valid;
    logic        frame_ready;
    logic        overrun;
    logic        locked;

    modport slave (
        input  hsync, vsync, red, green, blue, frame_ready,
        output frame_data, frame_valid, overrun, locked
    );

    modport master (
        output hsync, vsync, red, green, blue, frame_ready,
        input  frame_data, frame_valid, overrun, locked
    );
endinterface

// File: rtl/vga_capture.sv
// Samples a 64x64 pixel window of a VGA stream at 8x8 cell centres into a 64-bit
// bitmap and hands each completed frame to a valid/ready consumer.
module vga_capture #(
    parameter int HSTART = 479,
    parameter int VSTART = 275,
    parameter int THRESH = 24
) (
    input logic       dclk,
    input logic       clr,
    vga_capture_if.slave bus
);
    localparam logic [9:0] HS = HSTART[9:0];
    localparam logic [9:0] VS = VSTART[9:0];
    localparam logic [5:0] TH = THRESH[5:0];

    typedef enum logic [1:0] {SEEK, ARMED, CAPTURE} state_t;

    logic       hs_r, vs_r, hs_p, vs_p;
    logic [3:0] r_r, g_r, b_r;
    logic       hs_fall, vs_fall;
    logic [9:0] hcnt, vcnt, hoff, voff;
    logic [5:0] sum, idx;
    logic       pix, sample;

    state_t      state, state_nxt;
    logic [63:0] shadow, shadow_nxt;
    logic        complete, lock_set;
    logic [63:0] fd;
    logic        fv, ovr, lck;

    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            hs_r <= 1'b1;
            vs_r <= 1'b1;
            hs_p <= 1'b1;
            vs_p <= 1'b1;
            r_r  <= '0;
            g_r  <= '0;
            b_r  <= '0;
        end else begin
            hs_r <= bus.hsync;
            vs_r <= bus.vsync;
            hs_p <= hs_r;
            vs_p <= vs_r;
            r_r  <= bus.red;
            g_r  <= bus.green;
            b_r  <= bus.blue;
        end
    end

    assign hs_fall = hs_p & ~hs_r;
    assign vs_fall = vs_p & ~vs_r;

    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            hcnt <= '0;
            vcnt <= '0;
        end else begin
            if (hs_fall)               hcnt <= '0;
            else if (hcnt != 10'h3FF)  hcnt <= hcnt + 10'd1;
            if (vs_fall)                         vcnt <= '0;
            else if (hs_fall && vcnt != 10'h3FF) vcnt <= vcnt + 10'd1;
        end
    end

    assign sum  = {2'b00, r_r} + {2'b00, g_r} + {2'b00, b_r};
    assign pix  = (sum >= TH);
    assign hoff = hcnt - HS;
    assign voff = vcnt - VS;
    // Cell centre: inside the 64-wide window and at offset 4 within an 8-pixel cell
    assign sample = (hcnt >= HS) && (hoff[9:6] == 4'd0) && (hoff[2:0] == 3'd4) &&
                    (vcnt >= VS) && (voff[9:6] == 4'd0) && (voff[2:0] == 3'd4);
    assign idx = {voff[5:3], hoff[5:3]};

    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            state  <= SEEK;
            shadow <= '0;
        end else begin
            state  <= state_nxt;
            shadow <= shadow_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        shadow_nxt = shadow;
        complete   = 1'b0;
        lock_set   = 1'b0;
        case (state)
            SEEK: begin
                if (vs_fall) begin
                    state_nxt = ARMED;
                    lock_set  = 1'b1;
                end
            end
            ARMED: begin
                shadow_nxt = '0;
                if (sample && idx == 6'd0) begin
                    shadow_nxt[0] = pix;
                    state_nxt     = CAPTURE;
                end
            end
            CAPTURE: begin
                if (vs_fall) begin
                    state_nxt = ARMED;
                end else if (sample) begin
                    shadow_nxt[idx] = pix;
                    if (idx == 6'd63) begin
                        complete  = 1'b1;
                        state_nxt = ARMED;
                    end
                end
            end
            default: state_nxt = SEEK;
        endcase
    end

    // shadow_nxt already carries bit 63 in the completion cycle
    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            fd  <= '0;
            fv  <= 1'b0;
            ovr <= 1'b0;
            lck <= 1'b0;
        end else begin
            ovr <= 1'b0;
            if (lock_set) lck <= 1'b1;
            if (complete && (!fv || bus.frame_ready)) begin
                fd <= shadow_nxt;
                fv <= 1'b1;
            end else begin
                if (complete)                ovr <= 1'b1;
                if (fv && bus.frame_ready)   fv  <= 1'b0;
            end
        end
    end

    assign bus.frame_data  = fd;
    assign bus.frame_valid = fv;
    assign bus.overrun     = ovr;
    assign bus.locked      = lck;
endmodule

// File: tb/tb_vga_capture.sv
// Scoreboard bench for vga_capture using a shrunken raster so frames stay short;
// a monitor pops the expected frame each time the DUT presents a new one.
module tb_vga_capture;
    localparam int HSTART = 12;
    localparam int VSTART = 6;
    localparam int H_TOT  = 80;
    localparam int V_TOT  = 74;
    localparam int CV     = VSTART + 60;
    localparam int CH     = HSTART + 62;

    logic dclk = 1'b0;
    logic clr  = 1'b1;
    vga_capture_if bus();

    vga_capture #(.HSTART(HSTART), .VSTART(VSTART), .THRESH(24)) dut (
        .dclk(dclk),
        .clr (clr),
        .bus (bus)
    );

    always #20 dclk = ~dclk;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] last_pop = '0;
    int overruns = 0;
    int exp_overruns = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a new frame is presented when valid rises or is reloaded during a handshake
    initial begin
        logic fv_old;
        fv_old = 1'b0;
        forever begin
            @(posedge dclk);
            #1;
            if (bus.frame_valid && (!fv_old || bus.frame_ready)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got %h expected none", bus.frame_data);
                end else begin
                    last_pop = exp_q.pop_front();
                    chk("frame_data", bus.frame_data, last_pop);
                end
            end
            if (bus.overrun) begin
                overruns++;
                chk("hold_on_overrun", bus.frame_data, last_pop);
            end
            fv_old = bus.frame_valid;
        end
    end

    // One raster frame; mode 0 = vdata bitmap, 1 = rgb 8,8,7, 2 = rgb 8,8,8
    task automatic run_frame(input logic [63:0] vd, input int mode, input bit inj,
                             input int clr_line, input bit fr_lvl, input bit fr_pulse);
        for (int gv = 0; gv < V_TOT; gv++) begin
            for (int gh = 0; gh < H_TOT; gh++) begin
                int gx, gy;
                bit lit;
                @(negedge dclk);
                clr = (gv < clr_line);
                bus.hsync = !(gh < 8);
                bus.vsync = !((gv < 2) || (inj && gv == VSTART + 30));
                bus.frame_ready = fr_pulse ? (gv == CV && gh == CH) : fr_lvl;
                gx = gh - (HSTART + 1);
                gy = gv - VSTART;
                lit = (gx >= 0 && gx < 64 && gy >= 0 && gy < 64) ? vd[(gx / 8) + 8 * (gy / 8)] : 1'b0;
                case (mode)
                    1:       begin bus.red = 4'd8; bus.green = 4'd8; bus.blue = 4'd7; end
                    2:       begin bus.red = 4'd8; bus.green = 4'd8; bus.blue = 4'd8; end
                    default: begin
                        bus.red   = lit ? 4'd15 : 4'd0;
                        bus.green = lit ? 4'd15 : 4'd0;
                        bus.blue  = lit ? 4'd15 : 4'd0;
                    end
                endcase
            end
        end
    endtask

    initial begin
        bus.hsync = 1'b1;
        bus.vsync = 1'b1;
        bus.red = '0;
        bus.green = '0;
        bus.blue = '0;
        bus.frame_ready = 1'b1;
        repeat (3) @(negedge dclk);
        chk("reset_frame_data", bus.frame_data, 64'd0);
        chk("reset_frame_valid", {63'd0, bus.frame_valid}, 64'd0);
        chk("reset_overrun", {63'd0, bus.overrun}, 64'd0);
        chk("reset_locked", {63'd0, bus.locked}, 64'd0);

        // Reset released mid-frame: nothing captured until the next vsync fall
        run_frame(64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0, 20, 1'b1, 1'b0);
        chk("locked_before_vsync", {63'd0, bus.locked}, 64'd0);
        chk("valid_before_vsync", {63'd0, bus.frame_valid}, 64'd0);

        exp_q.push_back(64'hA5A5_5A5A_0F0F_F0F0);
        run_frame(64'hA5A5_5A5A_0F0F_F0F0, 0, 1'b0, 0, 1'b1, 1'b0);
        chk("locked_after_vsync", {63'd0, bus.locked}, 64'd1);
        exp_q.push_back(64'hA5A5_5A5A_0F0F_F0F0);
        run_frame(64'hA5A5_5A5A_0F0F_F0F0, 0, 1'b0, 0, 1'b1, 1'b0);

        // Injected vsync after row 3 drops that frame; the next one is intact
        run_frame(64'h0123_4567_89AB_CDEF, 0, 1'b1, 0, 1'b1, 1'b0);
        exp_q.push_back(64'h8000_0000_0000_0001);
        run_frame(64'h8000_0000_0000_0001, 0, 1'b0, 0, 1'b1, 1'b0);

        // Threshold boundary
        exp_q.push_back(64'd0);
        run_frame(64'd0, 1, 1'b0, 0, 1'b1, 1'b0);
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
        run_frame(64'd0, 2, 1'b0, 0, 1'b1, 1'b0);

        // Stalled consumer: first frame held, second dropped with overrun
        exp_q.push_back(64'd0);
        run_frame(64'd0, 0, 1'b0, 0, 1'b0, 1'b0);
        exp_overruns++;
        run_frame(64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0, 0, 1'b0, 1'b0);
        chk("data_held_after_overrun", bus.frame_data, 64'd0);

        // Ready exactly in the completion cycle: reload without overrun
        exp_q.push_back(64'h3C3C_C3C3_1234_8421);
        run_frame(64'h3C3C_C3C3_1234_8421, 0, 1'b0, 0, 1'b0, 1'b1);
        chk("valid_after_reload", {63'd0, bus.frame_valid}, 64'd1);

        bus.frame_ready = 1'b1;
        repeat (4) @(negedge dclk);
        chk("valid_cleared", {63'd0, bus.frame_valid}, 64'd0);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        chk("overrun_count", 64'(overruns), 64'(exp_overruns));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_capture.md
VGA_CAPTURE -- requirements
Module: vga_capture

Interface
REQ-001 Parameter HSTART, default 479: hcnt value of the first pixel column of the 64x64 capture window.
REQ-002 Parameter VSTART, default 275: vcnt value of the first line of the capture window.
REQ-003 Parameter THRESH, default 24: luminance threshold; pixel is 1 when red+green+blue >= THRESH.
REQ-004 dclk  input  1  pixel clock, 25 MHz.
REQ-005 clr  input  1  reset, asynchronous, active-high.
REQ-006 hsync  input  1  horizontal sync, active low.
REQ-007 vsync  input  1  vertical sync, active low.
REQ-008 red, green, blue  input  4 each  pixel colour.
REQ-009 frame_data  output  64  captured 8x8 bitmap; bit index = col + 8*row.
REQ-010 frame_valid  output  1  frame_data holds an undelivered frame.
REQ-011 frame_ready  input  1  consumer accepts frame_data when high with frame_valid.
REQ-012 overrun  output  1  one-cycle pulse: completed frame dropped.
REQ-013 locked  output  1  high once the first vsync fall after reset has been seen.

Function
REQ-014 The block SHALL register hsync, vsync, and RGB once; all further logic SHALL use only the registered copies (1-cycle input latency).
REQ-015 Sync falling edges SHALL be detected on the registered copies; reset SHALL initialise the previous-sync registers to 1.
REQ-016 hcnt (10 bit) SHALL load 0 in the cycle the hsync fall is detected, otherwise increment, saturating at 1023.
REQ-017 vcnt (10 bit) SHALL load 0 on a vsync fall; otherwise it SHALL increment on each hsync fall, saturating at 1023; vsync takes priority when both fall in the same cycle.
REQ-018 Sum red+green+blue SHALL be computed at 6 bits without overflow; pix = (sum >= THRESH).
REQ-019 A sample point SHALL be hcnt = HSTART+8c+4 and vcnt = VSTART+8r+4, c,r in 0..7; at a sample point, shadow bit (c+8r) SHALL be set to pix.
REQ-020 FSM states: SEEK, ARMED, CAPTURE.
REQ-021 SEEK: the block SHALL ignore samples; on a vsync fall it SHALL go to ARMED and set locked=1.
REQ-022 ARMED: the block SHALL clear the shadow register; at sample point (0,0) it SHALL store bit 0 and go to CAPTURE.
REQ-023 CAPTURE: the block SHALL store samples; at sample point (7,7) it SHALL store bit 63 and complete the frame, then go to ARMED.
REQ-024 A vsync fall while in CAPTURE before (7,7) SHALL discard the partial frame and go to ARMED; frame_valid and frame_data SHALL be unaffected.
REQ-025 On completion, if frame_valid=0 or frame_ready=1 in that cycle, frame_data SHALL load the full 64-bit frame (including bit 63) and frame_valid SHALL be 1 next cycle.
REQ-026 On completion with frame_valid=1 and frame_ready=0, the new frame SHALL be dropped, frame_data SHALL hold, and overrun SHALL pulse high for exactly one cycle.
REQ-027 frame_valid SHALL clear the cycle after a frame_valid & frame_ready handshake, unless REQ-025 reloads it in the same cycle.
REQ-028 frame_data SHALL remain stable while frame_valid=1 and no handshake occurs.
REQ-029 With default parameters, the block SHALL reproduce the 64-bit word driven into the team's 640x480 8x8-character display generator when fed that generator's sync and RGB outputs.

Reset
REQ-030 clr=1 SHALL asynchronously set: state=SEEK, hcnt=vcnt=0, shadow=0, frame_data=0, frame_valid=0, overrun=0, locked=0, registered syncs=1, registered RGB=0.
REQ-031 Asserting clr mid-capture SHALL lose the partial frame; after release the block SHALL capture nothing until the next vsync fall.

Verification
REQ-032 Display generator driven with vdata=64'hA5A5_5A5A_0F0F_F0F0, frame_ready=1 -> after the first complete frame, frame_valid pulses with frame_data=64'hA5A5_5A5A_0F0F_F0F0 once per frame.
REQ-033 vdata=0 then 64'hFFFF_FFFF_FFFF_FFFF, frame_ready=0 -> first frame 0 delivered and held; second frame gives overrun pulse of 1 cycle; frame_data stays 0.
REQ-034 Release clr mid-frame -> locked=0 and frame_valid=0 until the first vsync fall; first delivered frame is the next full frame.
REQ-035 Extra vsync fall injected after row 3 samples -> no frame_valid for that frame; next full frame is delivered correctly.
REQ-036 RGB held at 8,8,7 (sum 23) vs 8,8,8 (sum 24) across the window -> frame_data all zeros vs all ones.
REQ-037 frame_ready asserted in the completion cycle while frame_valid=1 -> new frame loaded, frame_valid stays 1, no overrun.
